// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and beat type for the writeback stage
package wb_pkg;

    localparam int WB_XLEN_MAX = 64;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // result is sized for the widest core; narrower builds use the low bits
    typedef struct packed {
        logic [WB_XLEN_MAX-1:0] result;
        logic [4:0]             rd;
        logic                   reg_write;
        logic                   misaligned;
    } wb_beat_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - shifts raw load data by byte offset and extends per funct3
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFFW = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0] read_data,
    input  logic [OFFW-1:0] off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted    = read_data >> {off, 3'b000};
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = XLEN'($signed(shifted[7:0]));
            F3_LBU: data = XLEN'(shifted[7:0]);
            F3_LH: begin
                data       = XLEN'($signed(shifted[15:0]));
                misaligned = off[0];
            end
            F3_LHU: begin
                data       = XLEN'(shifted[15:0]);
                misaligned = off[0];
            end
            F3_LW: begin
                data       = XLEN'($signed(shifted[31:0]));
                misaligned = |off[1:0];
            end
            F3_LWU: begin
                // only encodable on RV64
                if (XLEN == 64) begin
                    data       = XLEN'(shifted[31:0]);
                    misaligned = |off[1:0];
                end else begin
                    misaligned = 1'b1;
                end
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    data       = shifted;
                    misaligned = |off;
                end else begin
                    misaligned = 1'b1;
                end
            end
            default: misaligned = 1'b1;
        endcase
        if (misaligned) data = '0;
    end

endmodule

// File: rtl/wb_result_stage.sv
// rtl/wb_result_stage.sv - registered writeback select with two-entry skid buffer and forwarding port
module wb_result_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [1:0]      result_src,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_misaligned,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    localparam int OFFW = $clog2(XLEN/8);

    logic [XLEN-1:0] ld_data;
    logic            ld_mis;
    logic [XLEN-1:0] sel;
    logic            bad_load;
    wb_beat_t        beat;

    load_align #(.XLEN(XLEN)) u_load_align (
        .read_data  (read_data),
        .off        (alu_result[OFFW-1:0]),
        .funct3     (funct3),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    always_comb begin
        sel = '0;
        case (result_src)
            RES_ALU:  sel = alu_result;
            RES_LOAD: sel = ld_data;
            RES_PC4:  sel = pc_plus_4;
            RES_IMM:  sel = imm_ext;
            default:  sel = '0;
        endcase
        bad_load        = (result_src == RES_LOAD) && ld_mis;
        beat.result     = bad_load ? '0 : WB_XLEN_MAX'(sel);
        beat.rd         = rd;
        beat.reg_write  = reg_write && (rd != 5'd0) && !bad_load;
        beat.misaligned = bad_load;
    end

    wb_beat_t main_q, skid_q;
    logic     main_valid, skid_valid;
    logic     accept, main_free;

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign main_free = ~main_valid | out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // skid_valid implies in_ready=0, so a refill from skid never races a new beat
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= beat;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= beat;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid      = main_valid;
    assign result         = main_q.result[XLEN-1:0];
    assign out_rd         = main_q.rd;
    assign out_reg_write  = main_q.reg_write;
    assign out_misaligned = main_q.misaligned;

    assign fwd_valid = main_valid & main_q.reg_write;
    assign fwd_rd    = main_q.rd;
    assign fwd_data  = result;

endmodule

// File: tb/tb_wb_result_stage.sv
// tb/tb_wb_result_stage.sv - directed self-checking bench for wb_result_stage
module tb_wb_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid32, in_valid64;
    logic        out_ready;
    logic [63:0] alu_result, read_data, pc_plus_4, imm_ext;
    logic [1:0]  result_src;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;

    logic        in_ready32, out_valid32, out_reg_write32, out_mis32, fwd_valid32;
    logic [31:0] result32, fwd_data32;
    logic [4:0]  out_rd32, fwd_rd32;

    logic        in_ready64, out_valid64, out_reg_write64, out_mis64, fwd_valid64;
    logic [63:0] result64, fwd_data64;
    logic [4:0]  out_rd64, fwd_rd64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_result_stage #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .alu_result(alu_result[31:0]), .read_data(read_data[31:0]),
        .pc_plus_4(pc_plus_4[31:0]), .imm_ext(imm_ext[31:0]),
        .result_src(result_src), .funct3(funct3), .rd(rd), .reg_write(reg_write),
        .out_valid(out_valid32), .out_ready(out_ready),
        .result(result32), .out_rd(out_rd32), .out_reg_write(out_reg_write32),
        .out_misaligned(out_mis32), .fwd_valid(fwd_valid32), .fwd_rd(fwd_rd32),
        .fwd_data(fwd_data32)
    );

    wb_result_stage #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .alu_result(alu_result), .read_data(read_data),
        .pc_plus_4(pc_plus_4), .imm_ext(imm_ext),
        .result_src(result_src), .funct3(funct3), .rd(rd), .reg_write(reg_write),
        .out_valid(out_valid64), .out_ready(out_ready),
        .result(result64), .out_rd(out_rd64), .out_reg_write(out_reg_write64),
        .out_misaligned(out_mis64), .fwd_valid(fwd_valid64), .fwd_rd(fwd_rd64),
        .fwd_data(fwd_data64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic [1:0] src, input logic [2:0] f3,
                            input logic [63:0] alu, input logic [63:0] rdata,
                            input logic [4:0] d, input logic rw);
        result_src = src;
        funct3     = f3;
        alu_result = alu;
        read_data  = rdata;
        rd         = d;
        reg_write  = rw;
    endtask

    // present one beat for a single edge, then sample 1ns after it
    task automatic send32(input logic [1:0] src, input logic [2:0] f3,
                          input logic [63:0] alu, input logic [63:0] rdata,
                          input logic [4:0] d, input logic rw);
        set_beat(src, f3, alu, rdata, d, rw);
        in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
    endtask

    task automatic send64(input logic [2:0] f3, input logic [63:0] alu,
                          input logic [63:0] rdata);
        set_beat(2'b01, f3, alu, rdata, 5'd7, 1'b1);
        in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        out_ready  = 1'b1;
        pc_plus_4  = 64'h44;
        imm_ext    = 64'hABCD0000;
        set_beat(2'b00, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready32}, 64'd1);
        check("rst_result", {32'd0, result32}, 64'd0);
        check("rst_fwd_valid", {63'd0, fwd_valid32}, 64'd0);
        check("rst_misaligned", {63'd0, out_mis32}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        send32(2'b00, 3'b000, 64'h1234, 64'h0, 5'd3, 1'b1);
        check("sel_alu", {32'd0, result32}, 64'h1234);
        check("sel_alu_valid", {63'd0, out_valid32}, 64'd1);
        check("sel_alu_fwd", {59'd0, fwd_valid32, fwd_rd32}, {59'd0, 1'b1, 5'd3});
        check("sel_alu_fwd_data", {32'd0, fwd_data32}, 64'h1234);
        send32(2'b10, 3'b000, 64'h1234, 64'h0, 5'd3, 1'b1);
        check("sel_pc4", {32'd0, result32}, 64'h44);
        send32(2'b11, 3'b000, 64'h1234, 64'h0, 5'd3, 1'b1);
        check("sel_imm", {32'd0, result32}, 64'hABCD0000);

        send32(2'b01, 3'b000, 64'h3, 64'h80FF7F01, 5'd4, 1'b1);
        check("lb_off3", {32'd0, result32}, 64'hFFFFFF80);
        send32(2'b01, 3'b100, 64'h1, 64'h80FF7F01, 5'd4, 1'b1);
        check("lbu_off1", {32'd0, result32}, 64'h0000007F);
        send32(2'b01, 3'b001, 64'h2, 64'h80FF7F01, 5'd4, 1'b1);
        check("lh_off2", {32'd0, result32}, 64'hFFFF80FF);
        send32(2'b01, 3'b101, 64'h0, 64'h80FF7F01, 5'd4, 1'b1);
        check("lhu_off0", {32'd0, result32}, 64'h00007F01);
        send32(2'b01, 3'b010, 64'h0, 64'h80FF7F01, 5'd4, 1'b1);
        check("lw_off0", {32'd0, result32}, 64'h80FF7F01);

        send32(2'b01, 3'b010, 64'h2, 64'h80FF7F01, 5'd5, 1'b1);
        check("mis_result", {32'd0, result32}, 64'd0);
        check("mis_flags", {61'd0, out_reg_write32, out_mis32, fwd_valid32}, {61'd0, 3'b010});
        send32(2'b01, 3'b011, 64'h0, 64'h80FF7F01, 5'd5, 1'b1);
        check("ld_on_rv32_illegal", {62'd0, out_mis32, out_reg_write32}, {62'd0, 2'b10});
        send32(2'b01, 3'b101, 64'h1, 64'h80FF7F01, 5'd5, 1'b1);
        check("lhu_off1_mis", {62'd0, out_mis32, out_reg_write32}, {62'd0, 2'b10});

        send32(2'b00, 3'b000, 64'h55, 64'h0, 5'd0, 1'b1);
        check("x0_reg_write", {62'd0, out_reg_write32, fwd_valid32}, 64'd0);
        check("x0_valid", {63'd0, out_valid32}, 64'd1);
        @(posedge clk); #1;
        check("drain_empty", {62'd0, out_valid32, fwd_valid32}, 64'd0);

        // backpressure: A to main, B to skid, C held upstream
        out_ready = 1'b0;
        send32(2'b00, 3'b000, 64'h111, 64'h0, 5'd1, 1'b1);
        check("bp_a_main", {32'd0, result32}, 64'h111);
        check("bp_ready_after_a", {63'd0, in_ready32}, 64'd1);
        send32(2'b00, 3'b000, 64'h222, 64'h0, 5'd2, 1'b1);
        check("bp_full_ready", {63'd0, in_ready32}, 64'd0);
        check("bp_a_stable", {32'd0, result32}, 64'h111);
        set_beat(2'b00, 3'b000, 64'h333, 64'h0, 5'd3, 1'b1);
        in_valid32 = 1'b1;
        @(posedge clk); #1;
        check("bp_c_held", {63'd0, in_ready32}, 64'd0);
        check("bp_a_still", {27'd0, out_rd32, result32}, {27'd0, 5'd1, 32'h111});
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_b_out", {32'd0, result32}, 64'h222);
        check("bp_ready_back", {63'd0, in_ready32}, 64'd1);
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        check("bp_c_out", {32'd0, result32}, 64'h333);
        check("bp_c_valid", {63'd0, out_valid32}, 64'd1);
        @(posedge clk); #1;
        check("bp_drained", {63'd0, out_valid32}, 64'd0);

        // fill both entries then reset asynchronously mid-cycle
        out_ready = 1'b0;
        send32(2'b00, 3'b000, 64'hA, 64'h0, 5'd1, 1'b1);
        send32(2'b00, 3'b000, 64'hB, 64'h0, 5'd2, 1'b1);
        check("full_before_reset", {62'd0, out_valid32, in_ready32}, {62'd0, 2'b10});
        reset = 1'b1;
        #1;
        check("async_rst", {61'd0, out_valid32, in_ready32, fwd_valid32}, {61'd0, 3'b010});
        check("async_rst_result", {32'd0, result32}, 64'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        send64(3'b011, 64'h0, 64'h0123456789ABCDEF);
        check("rv64_ld", result64, 64'h0123456789ABCDEF);
        send64(3'b110, 64'h4, 64'hF000000000000000);
        check("rv64_lwu_off4", result64, 64'h00000000F0000000);
        send64(3'b010, 64'h4, 64'hF000000000000000);
        check("rv64_lw_off4", result64, 64'hFFFFFFFFF0000000);
        send64(3'b011, 64'h4, 64'hF000000000000000);
        check("rv64_ld_mis", {62'd0, out_mis64, out_reg_write64}, {62'd0, 2'b10});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
